wb_pingpong_buffer: RTL and testbench
=====================================

Name: wb_pingpong_buffer

Overview:
Double-banked, parametrised weight buffer for the NPU core.
- Weights arrive as a 32-bit lane stream from the AXI/DMA side. Lanes are packed into LANES*32-bit words and written into the fill bank.
- The MAC array reads full-width words from the other bank, so the next layer's weights load while the current layer computes.
- Bank ownership swaps under explicit fill-done / read-release handshakes.

Parameters:
LANES, 13, number of 32-bit lanes per word (read width = LANES*32).
AW, 13, word address width; each bank holds 2**AW words.
REG_OUT, 1, 1 = extra output register stage on read data; 0 = RAM output drives o_rdata directly.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
i_wr_data  in  32  lane write data
i_wr_vld  in  1  lane write valid
o_wr_rdy  out  1  fill bank can accept lanes
i_start_addr  in  AW  fill start word address
i_start_addr_en  in  1  load start address, reset lane pointer
i_fill_done  in  1  pulse: fill bank complete
i_rd_en  in  1  read request
i_rd_addr  in  AW  read word address
i_bypass  in  1  zero this read's data
i_rd_release  in  1  pulse: read bank consumed
o_rd_ready  out  1  read bank holds valid weights
o_rdata  out  LANES*32  read data
o_rdata_vld  out  1  read data valid
o_wr_ovf  out  1  sticky: write address wrapped
o_seq_err  out  1  sticky: fill_done or release issued illegally

Behaviour:
State registers:
- fill_sel, rd_sel (1 bit each).
- bank_full[1:0].
- lane pointer: one-hot, LANES bits.
- wr_addr (AW bits).
- Reset: all of the above = 0, lane pointer = lane0. o_rdata=0, o_rdata_vld=0, o_wr_ovf=0, o_seq_err=0. o_wr_rdy=1, o_rd_ready=0.

Write side:
- o_wr_rdy = ~bank_full[fill_sel].
- A lane is accepted when i_wr_vld & o_wr_rdy. Its lane data is written to bank[fill_sel], word wr_addr, at the lane indicated by the pointer (per-lane write enable; other lanes untouched). The pointer then rotates left.
- When the accepted lane is lane LANES-1: wr_addr increments, pointer returns to lane0.
- wr_addr = 2**AW-1 on the last lane: wraps to 0 and sets o_wr_ovf.
- i_start_addr_en has priority over an accept in the same cycle: wr_addr <= i_start_addr, pointer <= lane0, the lane is dropped.

Fill done (i_fill_done):
- If bank_full[fill_sel]=0: set bank_full[fill_sel], toggle fill_sel, wr_addr <= 0, pointer <= lane0.
- A partially packed last word keeps whatever lanes were written.
- If bank_full[fill_sel]=1: ignored, set o_seq_err.

Read side:
- o_rd_ready = bank_full[rd_sel].
- A read is accepted when i_rd_en & o_rd_ready. It reads bank[rd_sel] at i_rd_addr.
- i_rd_en while not ready: no RAM access, no o_rdata_vld.
- Latency from accepted read to o_rdata_vld: 1 cycle (REG_OUT=0) or 2 cycles (REG_OUT=1).
- i_bypass is pipelined with the read. o_rdata = 0 when the bypass flag is set; o_rdata_vld is still asserted.
- With REG_OUT=1, o_rdata holds its last value when no read is in flight.

Read release (i_rd_release):
- If bank_full[rd_sel]=1: clear it, toggle rd_sel.
- Otherwise: ignored, set o_seq_err.
- Reads already in flight complete normally.

Simultaneous events:
- fill_done and release in the same cycle both take effect. They act on different banks whenever both are legal.
- i_rd_en and i_rd_release in the same cycle: the read uses the old rd_sel.
- Write and read never touch the same bank in the same cycle (the read bank is full, the fill bank is not full).

Reset mid-operation: all control returns to reset values and both banks are treated as empty. RAM contents are not cleared.

Optional Feature:
WB_PERF_CNT_EN.
- Defined: adds outputs o_rd_reject_cnt[15:0] and o_swap_cnt[15:0].
  - o_rd_reject_cnt counts cycles with i_rd_en & ~o_rd_ready.
  - o_swap_cnt counts successful releases.
  - Both counters saturate at 16'hFFFF, reset to 0, and clear on i_start_addr_en.
- Undefined: ports and counters absent; all other behaviour is identical.

Decomposition:
- Shared package npu_wb_pkg holds:
  - LANE_W=32.
  - Default LANES/AW.
  - Bank-select typedef.
  - Function computing the read latency from REG_OUT.
- One sub-module, wb_bank_ram (parameters LANES, AW):
  - Simple dual-port, per-lane write enable, 1-cycle synchronous read.
  - Instantiated twice, one per bank.
  - The FPGA/ASIC macro wrapper choice lives inside it.

Test Plan:
1. LANES=13, start_addr=5, stream 26 lanes 0x00000001..0x0000001A, fill_done, rd_en addr 5 then 6. Required: o_rd_ready=1; word5 lane0=0x1, lane12=0xD; word6 lane0=0xE; o_rdata_vld exactly 2 cycles after each accepted read (REG_OUT=1).
2. Ping-pong: fill bank0, fill_done, stream bank1 while reading bank0 every cycle. Required: bank0 data is unchanged throughout. After release, o_rd_ready stays 1 and reads return bank1 data.
3. Both banks full: o_wr_rdy=0 and lanes are dropped. A second fill_done sets o_seq_err. A release with both banks empty also sets o_seq_err.
4. i_bypass=1 on a read of a nonzero word: o_rdata=0 and o_rdata_vld=1. The next read without bypass returns the true data.
5. AW=4, start_addr=15, 13 lanes: wr_addr wraps to 0 and o_wr_ovf=1. i_start_addr_en during a lane accept drops the lane and the pointer returns to lane0.
6. Assert i_rst_n=0 mid-fill, with a read in flight: o_rdata_vld=0 immediately, o_rd_ready=0, o_wr_rdy=1. With WB_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/npu_wb_pkg.sv
// ============================================================================
// Module : npu_wb_pkg
// Brief  : Shared constants, bank-select type and latency helper for the NPU
//          weight buffer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package npu_wb_pkg;

    localparam int LANE_W        = 32;
    localparam int DEFAULT_LANES = 13;
    localparam int DEFAULT_AW    = 13;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_sel_t;

    // Cycles from an accepted read to o_rdata_vld.
    function automatic int rd_latency(input int reg_out);
        return (reg_out != 0) ? 2 : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_bank_ram.sv
// ============================================================================
// Module : wb_bank_ram
// Brief  : One weight bank: simple dual-port RAM, per-lane write enable,
//          1-cycle synchronous read. Technology macro selection lives here.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_bank_ram
    import npu_wb_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int AW    = DEFAULT_AW
) (
    input  logic                    clk,
    input  logic [LANES-1:0]        we,
    input  logic [AW-1:0]           waddr,
    input  logic [LANE_W-1:0]       wdata,
    input  logic                    re,
    input  logic [AW-1:0]           raddr,
    output logic [LANES*LANE_W-1:0] rdata
);

    // Behavioural array per lane; swap for an FPGA BRAM or ASIC SRAM macro here.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] mem [2**AW];
        logic [LANE_W-1:0] lane_q;

        always_ff @(posedge clk) begin
            if (we[i]) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                lane_q <= mem[raddr];
            end
        end

        assign rdata[i*LANE_W +: LANE_W] = lane_q;
    end

endmodule

`default_nettype wire

// File: rtl/wb_pingpong_buffer.sv
// ============================================================================
// Module : wb_pingpong_buffer
// Brief  : Double-banked weight buffer; lane-packed fill bank, full-width read
//          bank, ownership swapped by fill-done / read-release handshakes.
//          Optional macro WB_PERF_CNT_EN adds reject / swap counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_pingpong_buffer
    import npu_wb_pkg::*;
#(
    parameter int LANES   = DEFAULT_LANES,
    parameter int AW      = DEFAULT_AW,
    parameter int REG_OUT = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [LANE_W-1:0]       i_wr_data,
    input  logic                    i_wr_vld,
    output logic                    o_wr_rdy,
    input  logic [AW-1:0]           i_start_addr,
    input  logic                    i_start_addr_en,
    input  logic                    i_fill_done,
    input  logic                    i_rd_en,
    input  logic [AW-1:0]           i_rd_addr,
    input  logic                    i_bypass,
    input  logic                    i_rd_release,
    output logic                    o_rd_ready,
    output logic [LANES*LANE_W-1:0] o_rdata,
    output logic                    o_rdata_vld,
    output logic                    o_wr_ovf,
`ifdef WB_PERF_CNT_EN
    output logic [15:0]             o_rd_reject_cnt,
    output logic [15:0]             o_swap_cnt,
`endif
    output logic                    o_seq_err
);

    localparam int             RD_LAT = rd_latency(REG_OUT);
    localparam logic [LANES-1:0] LANE0 = {{(LANES-1){1'b0}}, 1'b1};

    bank_sel_t          fill_sel;
    bank_sel_t          rd_sel;
    logic [1:0]         bank_full;
    logic [1:0]         bank_full_nxt;
    logic [LANES-1:0]   lane_ptr;
    logic [AW-1:0]      wr_addr;

    logic               wr_acc;
    logic               last_lane;
    logic               fill_ok;
    logic               rel_ok;
    logic               rd_acc;

    logic               p1_vld;
    logic               p1_byp;
    bank_sel_t          p1_sel;
    logic [LANES*LANE_W-1:0] bank_rdata [2];
    logic [LANES*LANE_W-1:0] ram_word;

    assign o_wr_rdy   = ~bank_full[fill_sel];
    assign o_rd_ready = bank_full[rd_sel];
    assign wr_acc     = i_wr_vld & o_wr_rdy & ~i_start_addr_en;
    assign last_lane  = lane_ptr[LANES-1];
    assign fill_ok    = i_fill_done & ~bank_full[fill_sel];
    assign rel_ok     = i_rd_release & bank_full[rd_sel];
    assign rd_acc     = i_rd_en & o_rd_ready;

    // A legal fill_done and a legal release always target different banks.
    always_comb begin
        bank_full_nxt = bank_full;
        if (fill_ok) begin
            bank_full_nxt[fill_sel] = 1'b1;
        end
        if (rel_ok) begin
            bank_full_nxt[rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fill_sel  <= BANK0;
            rd_sel    <= BANK0;
            bank_full <= 2'b00;
            lane_ptr  <= LANE0;
            wr_addr   <= '0;
            o_wr_ovf  <= 1'b0;
            o_seq_err <= 1'b0;
        end else begin
            if (wr_acc) begin
                if (last_lane) begin
                    lane_ptr <= LANE0;
                    wr_addr  <= wr_addr + AW'(1);
                    if (&wr_addr) begin
                        o_wr_ovf <= 1'b1;
                    end
                end else begin
                    lane_ptr <= {lane_ptr[LANES-2:0], lane_ptr[LANES-1]};
                end
            end
            if (fill_ok) begin
                fill_sel <= bank_sel_t'(~fill_sel);
                wr_addr  <= '0;
                lane_ptr <= LANE0;
            end
            // Start-address load wins over both a lane accept and a fill reset.
            if (i_start_addr_en) begin
                wr_addr  <= i_start_addr;
                lane_ptr <= LANE0;
            end
            if (rel_ok) begin
                rd_sel <= bank_sel_t'(~rd_sel);
            end
            if ((i_fill_done & ~fill_ok) | (i_rd_release & ~rel_ok)) begin
                o_seq_err <= 1'b1;
            end
            bank_full <= bank_full_nxt;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam bank_sel_t BANK_ID = bank_sel_t'(b);
        logic [LANES-1:0] we;
        logic             re;

        assign we = (wr_acc && (fill_sel == BANK_ID)) ? lane_ptr : '0;
        assign re = rd_acc && (rd_sel == BANK_ID);

        wb_bank_ram #(
            .LANES (LANES),
            .AW    (AW)
        ) u_ram (
            .clk   (i_clk),
            .we    (we),
            .waddr (wr_addr),
            .wdata (i_wr_data),
            .re    (re),
            .raddr (i_rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            p1_vld <= 1'b0;
            p1_byp <= 1'b0;
            p1_sel <= BANK0;
        end else begin
            p1_vld <= rd_acc;
            if (rd_acc) begin
                p1_byp <= i_bypass;
                p1_sel <= rd_sel;
            end
        end
    end

    assign ram_word = p1_byp ? '0 : bank_rdata[p1_sel];

    if (RD_LAT == 2) begin : g_reg_out
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                o_rdata     <= '0;
                o_rdata_vld <= 1'b0;
            end else begin
                o_rdata_vld <= p1_vld;
                if (p1_vld) begin
                    o_rdata <= ram_word;
                end
            end
        end
    end else begin : g_ram_out
        assign o_rdata_vld = p1_vld;
        assign o_rdata     = p1_vld ? ram_word : '0;
    end

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_reject_cnt <= '0;
            o_swap_cnt      <= '0;
        end else if (i_start_addr_en) begin
            o_rd_reject_cnt <= '0;
            o_swap_cnt      <= '0;
        end else begin
            if (i_rd_en && !o_rd_ready && !(&o_rd_reject_cnt)) begin
                o_rd_reject_cnt <= o_rd_reject_cnt + 16'd1;
            end
            if (rel_ok && !(&o_swap_cnt)) begin
                o_swap_cnt <= o_swap_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_pingpong_buffer.sv
// ============================================================================
// Module : tb_wb_pingpong_buffer
// Brief  : Self-checking bench for wb_pingpong_buffer against a bank-level
//          behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_pingpong_buffer;

    localparam int LANES   = 13;
    localparam int AW      = 6;
    localparam int REG_OUT = 1;
    localparam int W       = LANES * 32;
    localparam int DEPTH   = 1 << AW;
    localparam int LAT     = (REG_OUT != 0) ? 2 : 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   wr_data = '0;
    logic          wr_vld = 1'b0;
    logic          wr_rdy;
    logic [AW-1:0] start_addr = '0;
    logic          start_en = 1'b0;
    logic          fill_done = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          bypass = 1'b0;
    logic          rd_release = 1'b0;
    logic          rd_ready;
    logic [W-1:0]  rdata;
    logic          rdata_vld;
    logic          wr_ovf;
    logic          seq_err;
`ifdef WB_PERF_CNT_EN
    logic [15:0]   rej_cnt;
    logic [15:0]   swap_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_pingpong_buffer #(
        .LANES   (LANES),
        .AW      (AW),
        .REG_OUT (REG_OUT)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_wr_data       (wr_data),
        .i_wr_vld        (wr_vld),
        .o_wr_rdy        (wr_rdy),
        .i_start_addr    (start_addr),
        .i_start_addr_en (start_en),
        .i_fill_done     (fill_done),
        .i_rd_en         (rd_en),
        .i_rd_addr       (rd_addr),
        .i_bypass        (bypass),
        .i_rd_release    (rd_release),
        .o_rd_ready      (rd_ready),
        .o_rdata         (rdata),
        .o_rdata_vld     (rdata_vld),
        .o_wr_ovf        (wr_ovf),
`ifdef WB_PERF_CNT_EN
        .o_rd_reject_cnt (rej_cnt),
        .o_swap_cnt      (swap_cnt),
`endif
        .o_seq_err       (seq_err)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int           due;
        logic [W-1:0] data;
        logic [W-1:0] mask;
    } rd_t;

    int unsigned  mem   [2][DEPTH][LANES];
    bit           known [2][DEPTH][LANES];
    int           m_fill = 0, m_rd = 0, m_lane = 0, m_waddr = 0, cyc = 0;
    bit           m_full [2];
    bit           m_ovf = 0, m_seq = 0;
    int           m_rej = 0, m_swap = 0;
    rd_t          rq [$];
    logic [W-1:0] last_d = '0;
    logic [W-1:0] last_m = '1;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_fill = 0; m_rd = 0; m_lane = 0; m_waddr = 0; cyc = 0;
            m_full[0] = 0; m_full[1] = 0; m_ovf = 0; m_seq = 0;
            m_rej = 0; m_swap = 0;
            rq.delete();
            last_d = '0; last_m = '1;
        end else begin : model_step
            bit  pf0, pf1, f_full, r_full;
            int  fs, rs;
            rd_t e;
            cyc++;
            pf0 = m_full[0]; pf1 = m_full[1];
            fs = m_fill; rs = m_rd;
            f_full = (fs == 0) ? pf0 : pf1;
            r_full = (rs == 0) ? pf0 : pf1;
            if (rd_en && r_full) begin
                e.due = cyc + LAT - 1;
                e.data = '0; e.mask = '1;
                if (!bypass) begin
                    for (int l = 0; l < LANES; l++) begin
                        e.data[l*32 +: 32] = mem[rs][rd_addr][l];
                        e.mask[l*32 +: 32] = known[rs][rd_addr][l] ? 32'hFFFF_FFFF : 32'h0;
                    end
                end
                rq.push_back(e);
            end
            if (rd_en && !r_full && m_rej < 16'hFFFF) m_rej++;
            if (wr_vld && !f_full && !start_en) begin
                mem[fs][m_waddr][m_lane]   = wr_data;
                known[fs][m_waddr][m_lane] = 1'b1;
                m_lane++;
                if (m_lane == LANES) begin
                    m_lane = 0;
                    if (m_waddr == DEPTH - 1) begin m_waddr = 0; m_ovf = 1; end
                    else m_waddr++;
                end
            end
            if (fill_done) begin
                if (!f_full) begin
                    m_full[fs] = 1; m_fill = 1 - fs; m_waddr = 0; m_lane = 0;
                end else m_seq = 1;
            end
            if (rd_release) begin
                if (r_full) begin
                    m_full[rs] = 0; m_rd = 1 - rs;
                    if (m_swap < 16'hFFFF) m_swap++;
                end else m_seq = 1;
            end
            if (start_en) begin
                m_waddr = int'(start_addr); m_lane = 0; m_rej = 0; m_swap = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic exp_vld;
    rd_t  cur;
    initial forever begin
        @(negedge clk);
        exp_vld = (rq.size() > 0) && (rq[0].due == cyc);
        if (exp_vld) begin
            cur = rq.pop_front();
            last_d = cur.data; last_m = cur.mask;
        end
        chk("wr_rdy",    W'(wr_rdy),    W'(!m_full[m_fill]));
        chk("rd_ready",  W'(rd_ready),  W'(m_full[m_rd]));
        chk("wr_ovf",    W'(wr_ovf),    W'(m_ovf));
        chk("seq_err",   W'(seq_err),   W'(m_seq));
        chk("rdata_vld", W'(rdata_vld), W'(exp_vld));
        chk("rdata",     rdata & last_m, last_d & last_m);
`ifdef WB_PERF_CNT_EN
        chk("rej_cnt",   W'(rej_cnt),   W'(m_rej));
        chk("swap_cnt",  W'(swap_cnt),  W'(m_swap));
`endif
    end

    // ---------------- directed helpers ----------------
    task automatic push_lanes(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); wr_vld = 1'b1; wr_data = 32'(base + i);
        end
        @(negedge clk); wr_vld = 1'b0;
    endtask

    task automatic set_start(input int a);
        @(negedge clk); start_en = 1'b1; start_addr = AW'(a);
        @(negedge clk); start_en = 1'b0;
    endtask

    task automatic pulse_fill();
        @(negedge clk); fill_done = 1'b1;
        @(negedge clk); fill_done = 1'b0;
    endtask

    task automatic pulse_rel();
        @(negedge clk); rd_release = 1'b1;
        @(negedge clk); rd_release = 1'b0;
    endtask

    task automatic do_read(input int a, input bit byp, output logic [W-1:0] word);
        @(negedge clk); rd_en = 1'b1; rd_addr = AW'(a); bypass = byp;
        @(negedge clk); rd_en = 1'b0; bypass = 1'b0;
        chk("lat_early", W'(rdata_vld), W'(0));
        @(negedge clk);
        chk("lat_vld", W'(rdata_vld), W'(1));
        word = rdata;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [W-1:0] w;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_wr_rdy",    W'(wr_rdy),    W'(1));
        chk("rst_rd_ready",  W'(rd_ready),  W'(0));
        chk("rst_rdata_vld", W'(rdata_vld), W'(0));
        chk("rst_rdata",     rdata,         '0);
        #2 rst_n = 1'b1;

        // Packing across two words
        set_start(5);
        push_lanes(26, 1);
        pulse_fill();
        chk("t1_rd_ready", W'(rd_ready), W'(1));
        do_read(5, 0, w);
        chk("t1_w5_l0",  W'(w[0 +: 32]),   W'(32'h1));
        chk("t1_w5_l12", W'(w[384 +: 32]), W'(32'hD));
        do_read(6, 0, w);
        chk("t1_w6_l0",  W'(w[0 +: 32]),   W'(32'hE));

        // Fill bank1 while reading bank0 every cycle
        fork
            push_lanes(39, 32'h100);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk); rd_en = 1'b1; rd_addr = AW'(5 + (i % 2));
            end
        join
        @(negedge clk); rd_en = 1'b0;
        pulse_fill();
        chk("t3_wr_rdy_full", W'(wr_rdy), W'(0));
        push_lanes(3, 32'hBAD0);
        pulse_fill();
        chk("t3_seq_err", W'(seq_err), W'(1));
        pulse_rel();
        chk("t2_rd_ready", W'(rd_ready), W'(1));
        do_read(0, 0, w);
        chk("t2_b1_w0_l0", W'(w[0 +: 32]), W'(32'h100));

        // Bypass then true data
        do_read(1, 1, w);
        chk("t4_byp_zero", w, '0);
        do_read(1, 0, w);
        chk("t4_true", W'(w[0 +: 32]), W'(32'h10D));

        // Release with both banks empty
        do_reset();
        pulse_rel();
        chk("t3_rel_empty_seq", W'(seq_err), W'(1));

        // Address wrap, then start_addr_en during a lane accept
        do_reset();
        set_start(DEPTH - 1);
        push_lanes(13, 32'h300);
        chk("t5_ovf", W'(wr_ovf), W'(1));
        @(negedge clk); start_en = 1'b1; start_addr = AW'(2); wr_vld = 1'b1; wr_data = 32'hDEAD;
        @(negedge clk); start_en = 1'b0; wr_vld = 1'b0;
        push_lanes(13, 32'h200);
        pulse_fill();
        do_read(2, 0, w);
        chk("t5_drop_l0", W'(w[0 +: 32]), W'(32'h200));

        // Reset mid-fill with a read in flight
        @(negedge clk); rd_en = 1'b1; rd_addr = AW'(2); wr_vld = 1'b1; wr_data = 32'h55;
        @(negedge clk); rd_en = 1'b0;
        @(negedge clk); wr_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_vld",      W'(rdata_vld), W'(0));
        chk("t6_rd_ready", W'(rd_ready),  W'(0));
        chk("t6_wr_rdy",   W'(wr_rdy),    W'(1));
`ifdef WB_PERF_CNT_EN
        chk("t6_rej",      W'(rej_cnt),   W'(0));
        chk("t6_swap",     W'(swap_cnt),  W'(0));
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            wr_vld     = ($urandom_range(0, 1) == 1);
            wr_data    = $urandom;
            start_en   = ($urandom_range(0, 49) == 0);
            start_addr = AW'($urandom_range(0, 7));
            fill_done  = !start_en && ($urandom_range(0, 29) == 0);
            rd_release = ($urandom_range(0, 29) == 0);
            rd_en      = ($urandom_range(0, 1) == 1);
            rd_addr    = AW'($urandom_range(0, 7));
            bypass     = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        wr_vld = 0; start_en = 0; fill_done = 0; rd_release = 0; rd_en = 0; bypass = 0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
